// File: rtl/diff_word_decode_if.sv
// Handshake bundle for the differential word decoder: input word stream and
// decoded word stream, each with its own valid/ready pair.
interface diff_word_decode_if #(
  parameter int N = 8
);
  logic           in_valid;
  logic           in_ready;
  logic [2*N-1:0] word_in;
  logic           out_valid;
  logic           out_ready;
  logic [2*N-1:0] word_out;

  modport master (
    output in_valid,
    output word_in,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  word_out
  );

  modport slave (
    input  in_valid,
    input  word_in,
    input  out_ready,
    output in_ready,
    output out_valid,
    output word_out
  );
endinterface

// File: rtl/diff_word_decode.sv
// Differential word decoder: rebuilds the original base-4 word by mod-4
// accumulation from the MSB digit down, one digit per clock.
module diff_word_decode #(
  parameter int N     = 8,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  diff_word_decode_if.slave    bus,
  output logic [CNT_W-1:0]     word_cnt
);

  localparam int IDX_W = $clog2(N);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] DECODE = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;

  logic [1:0]       state;
  logic [2*N-1:0]   diff_reg;
  logic [2*N-1:0]   acc;
  logic [2*N-1:0]   acc_next;
  logic [2*N-1:0]   word_out_q;
  logic [IDX_W-1:0] idx;
  logic             out_valid_q;

  // Only digit idx changes per cycle; it adds the already-decoded digit above it.
  always_comb begin
    acc_next = acc;
    for (int unsigned i = 0; i < N - 1; i++) begin
      if (idx == IDX_W'(i)) begin
        acc_next[2*i +: 2] = diff_reg[2*i +: 2] + acc[2*i+2 +: 2];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      diff_reg    <= '0;
      acc         <= '0;
      idx         <= '0;
      word_out_q  <= '0;
      out_valid_q <= 1'b0;
      word_cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            diff_reg <= bus.word_in;
            acc      <= {bus.word_in[2*N-1 -: 2], {(2*N-2){1'b0}}};
            idx      <= IDX_W'(N - 2);
            state    <= DECODE;
          end
        end
        DECODE: begin
          acc <= acc_next;
          if (idx == '0) begin
            word_out_q  <= acc_next;
            out_valid_q <= 1'b1;
            state       <= DONE;
          end else begin
            idx <= idx - 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            word_cnt    <= word_cnt + 1'b1;
            state       <= IDLE;
          end
        end
        default: begin
          state       <= IDLE;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.word_out  = word_out_q;

endmodule

// File: tb/tb_diff_word_decode.sv
// Bench for diff_word_decode: fixed vectors, latency, backpressure, reset
// abort and a randomized encode/decode round trip through a queue.
module tb_diff_word_decode;

  localparam int N     = 8;
  localparam int CNT_W = 16;
  localparam int W     = 2 * N;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [CNT_W-1:0] word_cnt;

  diff_word_decode_if #(.N(N)) bus ();

  diff_word_decode #(.N(N), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus.slave),
    .word_cnt (word_cnt)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  int unsigned exp_cnt = 0;
  logic [W-1:0] sb[$];

  // Forward differential encoder: MSB digit passes, others are (w[i] - w[i+1]) mod 4.
  function automatic logic [W-1:0] encode(input logic [W-1:0] w);
    logic [W-1:0] e;
    e[W-1 -: 2] = w[W-1 -: 2];
    for (int i = 0; i < N - 1; i++) begin
      e[2*i +: 2] = w[2*i +: 2] - w[2*i+2 +: 2];
    end
    return e;
  endfunction

  task automatic test_reset();
    rst = 1'b0;
    bus.in_valid  = 1'b0;
    bus.word_in   = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.word_out !== '0 || word_cnt !== '0) begin
      n_fail++;
      $display("FAIL reset_state: in_ready=%b out_valid=%b word_out=%h word_cnt=%0d, expected 1 0 0000 0",
               bus.in_ready, bus.out_valid, bus.word_out, word_cnt);
    end
    rst = 1'b1;
    exp_cnt = 0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int lat;
    logic [W-1:0] exp_w;
    bus.out_ready = 1'b1;
    bus.word_in   = 16'h1555;
    bus.in_valid  = 1'b1;
    sb.push_back(16'h1B1B);
    @(negedge clk);
    bus.in_valid = 1'b0;
    n_tests++;
    if (bus.in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_in_ready_drop: in_ready=%b, expected 0", bus.in_ready);
    end
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    n_tests++;
    if (lat != N - 1) begin
      n_fail++;
      $display("FAIL basic_latency: %0d edges, expected %0d", lat, N - 1);
    end
    exp_w = (sb.size() != 0) ? sb.pop_front() : 'x;
    n_tests++;
    if (bus.word_out !== exp_w) begin
      n_fail++;
      $display("FAIL basic_word: word_out=%h, expected %h", bus.word_out, exp_w);
    end
    @(negedge clk);
    exp_cnt++;
    n_tests++;
    if (word_cnt !== CNT_W'(exp_cnt) || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_handshake: word_cnt=%0d out_valid=%b in_ready=%b, expected %0d 0 1",
               word_cnt, bus.out_valid, bus.in_ready, exp_cnt);
    end
  endtask

  task automatic test_vectors();
    logic [W-1:0] vin  [3];
    logic [W-1:0] vexp [3];
    logic [W-1:0] exp_w;
    int lat;
    vin[0] = 16'hFFFF; vexp[0] = 16'hE4E4;
    vin[1] = 16'h0000; vexp[1] = 16'h0000;
    vin[2] = 16'hC000; vexp[2] = 16'hFFFF;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      bus.word_in  = vin[k];
      bus.in_valid = 1'b1;
      sb.push_back(vexp[k]);
      @(negedge clk);
      bus.in_valid = 1'b0;
      lat = 0;
      while (bus.out_valid !== 1'b1 && lat < 50) begin
        @(negedge clk);
        lat++;
      end
      exp_w = (sb.size() != 0) ? sb.pop_front() : 'x;
      n_tests++;
      if (bus.out_valid !== 1'b1 || bus.word_out !== exp_w) begin
        n_fail++;
        $display("FAIL vector_%h: out_valid=%b word_out=%h, expected 1 %h",
                 vin[k], bus.out_valid, bus.word_out, exp_w);
      end
      @(negedge clk);
      exp_cnt++;
      n_tests++;
      if (word_cnt !== CNT_W'(exp_cnt)) begin
        n_fail++;
        $display("FAIL vector_cnt_%h: word_cnt=%0d, expected %0d", vin[k], word_cnt, exp_cnt);
      end
    end
  endtask

  task automatic test_backpressure();
    int lat;
    logic [W-1:0] exp_w;
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.word_in   = 16'h1555;
    bus.in_valid  = 1'b1;
    sb.push_back(16'h1B1B);
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    exp_w = (sb.size() != 0) ? sb.pop_front() : 'x;
    for (int c = 0; c < 5; c++) begin
      bus.word_in  = 16'hFFFF;
      bus.in_valid = 1'b1;
      @(negedge clk);
      n_tests++;
      if (bus.word_out !== exp_w || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL backpressure_hold_%0d: word_out=%h in_ready=%b out_valid=%b, expected %h 0 1",
                 c, bus.word_out, bus.in_ready, bus.out_valid, exp_w);
      end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    exp_cnt++;
    n_tests++;
    if (word_cnt !== CNT_W'(exp_cnt) || bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL backpressure_release: word_cnt=%0d in_ready=%b out_valid=%b, expected %0d 1 0",
               word_cnt, bus.in_ready, bus.out_valid, exp_cnt);
    end
    repeat (12) @(negedge clk);
    n_tests++;
    if (bus.out_valid !== 1'b0 || word_cnt !== CNT_W'(exp_cnt)) begin
      n_fail++;
      $display("FAIL backpressure_ignored_word: out_valid=%b word_cnt=%0d, expected 0 %0d",
               bus.out_valid, word_cnt, exp_cnt);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    logic [W-1:0] exp_w;
    bus.out_ready = 1'b1;
    bus.word_in   = 16'hFFFF;
    bus.in_valid  = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    sb.delete();
    exp_cnt = 0;
    n_tests++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.word_out !== '0 || word_cnt !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_state: in_ready=%b out_valid=%b word_out=%h word_cnt=%0d, expected 1 0 0000 0",
               bus.in_ready, bus.out_valid, bus.word_out, word_cnt);
    end
    bus.word_in  = 16'h1555;
    bus.in_valid = 1'b1;
    sb.push_back(16'h1B1B);
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    exp_w = (sb.size() != 0) ? sb.pop_front() : 'x;
    n_tests++;
    if (bus.out_valid !== 1'b1 || bus.word_out !== exp_w) begin
      n_fail++;
      $display("FAIL reset_mid_redecode: out_valid=%b word_out=%h, expected 1 %h",
               bus.out_valid, bus.word_out, exp_w);
    end
    @(negedge clk);
    exp_cnt++;
    n_tests++;
    if (word_cnt !== CNT_W'(exp_cnt)) begin
      n_fail++;
      $display("FAIL reset_mid_cnt: word_cnt=%0d, expected %0d", word_cnt, exp_cnt);
    end
  endtask

  task automatic test_random();
    int sent = 0;
    int got  = 0;
    int cyc  = 0;
    logic [W-1:0] pend;
    logic [W-1:0] exp_w;
    rst = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    sb.delete();
    exp_cnt = 0;
    pend = W'($urandom);
    while (got < 1000 && cyc < 40000) begin
      @(negedge clk);
      cyc++;
      bus.out_ready = 1'($urandom_range(0, 1));
      bus.in_valid  = (sent < 1000);
      bus.word_in   = encode(pend);
      if (bus.in_valid && bus.in_ready) begin
        sb.push_back(pend);
        sent++;
        pend = W'($urandom);
      end
      if (bus.out_valid === 1'b1 && bus.out_ready) begin
        exp_w = (sb.size() != 0) ? sb.pop_front() : 'x;
        n_tests++;
        if (bus.word_out !== exp_w) begin
          n_fail++;
          $display("FAIL round_trip_%0d: word_out=%h, expected %h", got, bus.word_out, exp_w);
        end
        got++;
        exp_cnt++;
      end
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    n_tests++;
    if (got != 1000) begin
      n_fail++;
      $display("FAIL round_trip_timeout: %0d words received, expected 1000", got);
    end
    n_tests++;
    if (word_cnt !== CNT_W'(exp_cnt) || word_cnt !== CNT_W'(1000)) begin
      n_fail++;
      $display("FAIL round_trip_cnt: word_cnt=%0d, expected %0d", word_cnt, 1000);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_vectors();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
